ts_bus_sched: RTL and testbench



---
 rtl/ts_bus_sched.sv | 232 +++++++++++++++++++++++
 tb/tb_ts_bus_sched.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_bus_sched.sv
// Shares the Turbosound-FM AY-style bus between the CPU port decoder and a register-stream player.
// Player writes are hidden from the CPU by restoring the shadowed address latch and select byte.
module ts_bus_sched #(
    parameter int STB_LEN = 4,
    parameter int GAP_LEN = 4,
    parameter int RD_LAT  = 4
) (
    input  logic       CLK,
    input  logic       RESET_s,
    input  logic       cpu_req,
    input  logic       cpu_wr,
    input  logic       cpu_a,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic       cpu_ack,
    input  logic       pl_req,
    input  logic       pl_chip,
    input  logic [7:0] pl_reg,
    input  logic [7:0] pl_data,
    output logic       pl_ack,
    output logic       BDIR,
    output logic       BC,
    output logic [7:0] DI,
    input  logic [7:0] DO,
    output logic       busy,
    output logic [2:0] dbg_state
);

    // Handshake: a requester raises req and holds it until the one-cycle ack,
    // then must drop it in the cycle after ack or a new transaction starts.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        W_STB  = 3'd1,
        W_GAP  = 3'd2,
        RD     = 3'd3,
        PL_STB = 3'd4,
        PL_GAP = 3'd5
    } state_t;

    localparam logic [7:0] STB_LAST = 8'(STB_LEN - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_LEN - 1);
    localparam logic [7:0] RD_LAST  = 8'(RD_LAT - 1);

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [2:0] phase, phase_n;
    logic       bdir_n, bc_n;
    logic [7:0] di_n;
    logic       cpu_ack_n, pl_ack_n;
    logic [7:0] rdata_n;

    logic       a_q, a_n;
    logic [7:0] wd_q, wd_n;
    logic       plc_q, plc_n;
    logic [7:0] plr_q, plr_n;
    logic [7:0] pld_q, pld_n;

    logic [7:0] sel_sh, sel_n;
    logic [7:0] adr_sh [2];
    logic [7:0] adr_n  [2];

    logic [2:0] ph_next;
    logic       nxt_bc;
    logic [7:0] nxt_di;

    // Bus contents for the phase following the current one.
    assign ph_next = phase + 3'd1;

    always_comb begin
        nxt_bc = 1'b1;
        nxt_di = {5'b11111, sel_sh[2:1], plc_q};
        case (ph_next)
            3'd1: nxt_di = plr_q;
            3'd2: begin
                nxt_bc = 1'b0;
                nxt_di = pld_q;
            end
            3'd3: nxt_di = adr_sh[plc_q];
            3'd4: nxt_di = sel_sh;
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        phase_n = phase;
        bdir_n  = BDIR;
        bc_n    = BC;
        di_n    = DI;
        a_n     = a_q;
        wd_n    = wd_q;
        plc_n   = plc_q;
        plr_n   = plr_q;
        pld_n   = pld_q;
        sel_n   = sel_sh;
        adr_n   = adr_sh;

        case (state)
            IDLE: begin
                if (cpu_req) begin
                    a_n   = cpu_a;
                    wd_n  = cpu_wdata;
                    cnt_n = '0;
                    bc_n  = cpu_a;
                    if (cpu_wr) begin
                        state_n = W_STB;
                        bdir_n  = 1'b1;
                        di_n    = cpu_wdata;
                    end else begin
                        state_n = RD;
                        bdir_n  = 1'b0;
                    end
                end else if (pl_req) begin
                    plc_n   = pl_chip;
                    plr_n   = pl_reg;
                    pld_n   = pl_data;
                    state_n = PL_STB;
                    phase_n = '0;
                    cnt_n   = '0;
                    bdir_n  = 1'b1;
                    bc_n    = 1'b1;
                    di_n    = {5'b11111, sel_sh[2:1], pl_chip};
                end
            end
            W_STB, PL_STB: begin
                if (cnt == STB_LAST) begin
                    state_n = (state == W_STB) ? W_GAP : PL_GAP;
                    cnt_n   = '0;
                    bdir_n  = 1'b0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            W_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            RD: begin
                if (cnt == RD_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            PL_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n = '0;
                    if (phase == 3'd4) begin
                        state_n = IDLE;
                    end else begin
                        state_n = PL_STB;
                        phase_n = ph_next;
                        bdir_n  = 1'b1;
                        bc_n    = nxt_bc;
                        di_n    = nxt_di;
                    end
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                bdir_n  = 1'b0;
            end
        endcase

        // Acks are registered so they land in the last cycle of the transaction.
        cpu_ack_n = ((state_n == W_GAP) && (cnt_n == GAP_LAST)) ||
                    ((state_n == RD) && (cnt_n == RD_LAST));
        pl_ack_n  = (state_n == PL_GAP) && (phase_n == 3'd4) && (cnt_n == GAP_LAST);
        rdata_n   = ((state_n == RD) && (cnt_n == RD_LAST)) ? DO : cpu_rdata;

        if ((state_n == W_GAP) && (cnt_n == GAP_LAST) && a_q) begin
            if (wd_q[7:3] == 5'b11111) begin
                sel_n = wd_q;
            end else begin
                adr_n[sel_sh[0]] = wd_q;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET_s) begin
        if (RESET_s) begin
            state     <= IDLE;
            cnt       <= '0;
            phase     <= '0;
            BDIR      <= 1'b0;
            BC        <= 1'b0;
            DI        <= 8'h00;
            cpu_rdata <= 8'h00;
            cpu_ack   <= 1'b0;
            pl_ack    <= 1'b0;
            a_q       <= 1'b0;
            wd_q      <= 8'h00;
            plc_q     <= 1'b0;
            plr_q     <= 8'h00;
            pld_q     <= 8'h00;
            sel_sh    <= 8'hFF;
            adr_sh[0] <= 8'h00;
            adr_sh[1] <= 8'h00;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            phase     <= phase_n;
            BDIR      <= bdir_n;
            BC        <= bc_n;
            DI        <= di_n;
            cpu_rdata <= rdata_n;
            cpu_ack   <= cpu_ack_n;
            pl_ack    <= pl_ack_n;
            a_q       <= a_n;
            wd_q      <= wd_n;
            plc_q     <= plc_n;
            plr_q     <= plr_n;
            pld_q     <= pld_n;
            sel_sh    <= sel_n;
            adr_sh[0] <= adr_n[0];
            adr_sh[1] <= adr_n[1];
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_ts_bus_sched.sv
// Directed bench for ts_bus_sched: a table of CPU transactions plus hand sequences
// for player sequences, CPU/player contention and reset during a player write.
module tb_ts_bus_sched;

    localparam int STB = 4;
    localparam int GAP = 4;
    localparam int RDL = 4;
    localparam int PH  = STB + GAP;

    logic       CLK = 1'b0;
    logic       RESET_s = 1'b1;
    logic       cpu_req = 1'b0;
    logic       cpu_wr = 1'b0;
    logic       cpu_a = 1'b0;
    logic [7:0] cpu_wdata = 8'h00;
    logic [7:0] cpu_rdata;
    logic       cpu_ack;
    logic       pl_req = 1'b0;
    logic       pl_chip = 1'b0;
    logic [7:0] pl_reg = 8'h00;
    logic [7:0] pl_data = 8'h00;
    logic       pl_ack;
    logic       BDIR;
    logic       BC;
    logic [7:0] DI;
    logic [7:0] DO = 8'h00;
    logic       busy;
    logic [2:0] dbg_state;

    ts_bus_sched #(.STB_LEN(STB), .GAP_LEN(GAP), .RD_LAT(RDL)) dut (
        .CLK(CLK), .RESET_s(RESET_s),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_a(cpu_a), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .pl_req(pl_req), .pl_chip(pl_chip), .pl_reg(pl_reg), .pl_data(pl_data),
        .pl_ack(pl_ack),
        .BDIR(BDIR), .BC(BC), .DI(DI), .DO(DO),
        .busy(busy), .dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       wr;
        logic       a;
        logic [7:0] wdata;
        logic [7:0] do_val;
        logic [7:0] exp_rdata;
        logic [7:0] exp_sel;
        logic [7:0] exp_adr0;
        logic [7:0] exp_adr1;
    } vec_t;

    vec_t vecs [10];

    int n_vec = 0;
    int n_err = 0;

    logic       bdir_at [0:127];
    logic       bc_at   [0:127];
    logic [7:0] di_at   [0:127];
    int         cpu_ack_j, pl_ack_j, cpu_ack_n, pl_ack_n;
    logic [7:0] rdata_ack, sel_ack, adr0_ack, adr1_ack;
    logic       busy_after;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge with requests already driven; records one value per cycle.
    task automatic run(input int max_p);
        cpu_ack_j = 0;
        pl_ack_j  = 0;
        cpu_ack_n = 0;
        pl_ack_n  = 0;
        for (int j = 1; j <= max_p; j++) begin
            @(negedge CLK);
            bdir_at[j] = BDIR;
            bc_at[j]   = BC;
            di_at[j]   = DI;
            if (cpu_ack) begin
                cpu_ack_n++;
                if (cpu_ack_j == 0) cpu_ack_j = j;
                rdata_ack = cpu_rdata;
                sel_ack   = dut.sel_sh;
                adr0_ack  = dut.adr_sh[0];
                adr1_ack  = dut.adr_sh[1];
                cpu_req   = 1'b0;
            end
            if (pl_ack) begin
                pl_ack_n++;
                if (pl_ack_j == 0) pl_ack_j = j;
                pl_req = 1'b0;
            end
            if (!cpu_req && !pl_req) break;
        end
        chk("timeout", {30'd0, cpu_req, pl_req}, 32'd0);
        cpu_req = 1'b0;
        pl_req  = 1'b0;
        @(negedge CLK);
        busy_after = busy;
    endtask

    task automatic cpu_vec(input vec_t v, input int idx);
        int exp_ack;
        int bad_bdir, bad_bc, bad_di;
        cpu_wr    = v.wr;
        cpu_a     = v.a;
        cpu_wdata = v.wdata;
        DO        = v.do_val;
        cpu_req   = 1'b1;
        run(40);
        exp_ack = v.wr ? PH : RDL;
        chk($sformatf("v%0d_ack_cycle", idx), cpu_ack_j, exp_ack);
        chk($sformatf("v%0d_ack_count", idx), {cpu_ack_n[15:0], pl_ack_n[15:0]}, 32'h0001_0000);
        bad_bdir = 0;
        bad_bc   = 0;
        bad_di   = 0;
        for (int j = 1; j <= exp_ack; j++) begin
            if (bdir_at[j] !== (v.wr && (j <= STB))) bad_bdir++;
            if (bc_at[j] !== v.a) bad_bc++;
            if (di_at[j] !== v.wdata) bad_di++;
        end
        chk($sformatf("v%0d_bdir_shape", idx), bad_bdir, 0);
        chk($sformatf("v%0d_bc_held", idx), bad_bc, 0);
        if (v.wr) chk($sformatf("v%0d_di_held", idx), bad_di, 0);
        else chk($sformatf("v%0d_rdata", idx), rdata_ack, v.exp_rdata);
        chk($sformatf("v%0d_shadows", idx), {8'd0, sel_ack, adr0_ack, adr1_ack},
            {8'd0, v.exp_sel, v.exp_adr0, v.exp_adr1});
        chk($sformatf("v%0d_idle_after", idx), busy_after, 1'b0);
    endtask

    // Player phases begin at cycle s; exp_di holds phase 0 in its top byte.
    task automatic check_player(input string tag, input int s,
                                input logic [39:0] exp_di, input logic [4:0] exp_bc);
        int bad_bdir;
        chk({tag, "_pl_ack_cycle"}, pl_ack_j, s - 1 + 5 * PH);
        for (int p = 0; p < 5; p++) begin
            chk($sformatf("%s_phase%0d_bus", tag, p), {23'd0, bc_at[s + p * PH], di_at[s + p * PH]},
                {23'd0, exp_bc[4 - p], exp_di[39 - 8 * p -: 8]});
        end
        bad_bdir = 0;
        for (int j = s; j < s + 5 * PH; j++) begin
            if (bdir_at[j] !== (((j - s) % PH) < STB)) bad_bdir++;
        end
        chk({tag, "_pl_bdir_shape"}, bad_bdir, 0);
    endtask

    task automatic pl_vec(input string tag, input logic chip, input logic [7:0] rg,
                          input logic [7:0] data, input logic [39:0] exp_di);
        pl_chip = chip;
        pl_reg  = rg;
        pl_data = data;
        pl_req  = 1'b1;
        run(60);
        chk({tag, "_ack_counts"}, {cpu_ack_n[15:0], pl_ack_n[15:0]}, 32'h0000_0001);
        check_player(tag, 1, exp_di, 5'b11011);
        chk({tag, "_shadows_kept"}, {8'd0, dut.sel_sh, dut.adr_sh[0], dut.adr_sh[1]},
            {8'd0, 8'hFE, 8'hF7, 8'h2A});
    endtask

    task automatic do_reset;
        RESET_s = 1'b1;
        repeat (2) @(negedge CLK);
        RESET_s = 1'b0;
    endtask

    initial begin
        int acks, highs;

        vecs[0] = '{1'b1, 1'b1, 8'hFE, 8'h00, 8'h00, 8'hFE, 8'h00, 8'h00};
        vecs[1] = '{1'b1, 1'b1, 8'h07, 8'h00, 8'h00, 8'hFE, 8'h07, 8'h00};
        vecs[2] = '{1'b1, 1'b0, 8'h38, 8'h00, 8'h00, 8'hFE, 8'h07, 8'h00};
        vecs[3] = '{1'b0, 1'b1, 8'h00, 8'hA5, 8'hA5, 8'hFE, 8'h07, 8'h00};
        vecs[4] = '{1'b1, 1'b1, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h07, 8'h00};
        vecs[5] = '{1'b1, 1'b1, 8'h2A, 8'h00, 8'h00, 8'hFF, 8'h07, 8'h2A};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 8'h3C, 8'h3C, 8'hFF, 8'h07, 8'h2A};
        vecs[7] = '{1'b1, 1'b1, 8'hF8, 8'h00, 8'h00, 8'hF8, 8'h07, 8'h2A};
        vecs[8] = '{1'b1, 1'b1, 8'hF7, 8'h00, 8'h00, 8'hF8, 8'hF7, 8'h2A};
        vecs[9] = '{1'b1, 1'b1, 8'hFE, 8'h00, 8'h00, 8'hFE, 8'hF7, 8'h2A};

        // Reset state
        repeat (3) @(negedge CLK);
        RESET_s = 1'b0;
        @(negedge CLK);
        chk("reset_outputs", {13'd0, BDIR, BC, DI, cpu_ack, pl_ack, busy, dbg_state},
            32'd0);
        chk("reset_rdata", cpu_rdata, 8'h00);
        chk("reset_shadows", {8'd0, dut.sel_sh, dut.adr_sh[0], dut.adr_sh[1]},
            {8'd0, 8'hFF, 8'h00, 8'h00});

        // CPU transaction table
        for (int i = 0; i < 10; i++) cpu_vec(vecs[i], i);

        // Player sequences with sel=FE, adr0=F7, adr1=2A
        pl_vec("pl_chip1", 1'b1, 8'h08, 8'h0F, {8'hFF, 8'h08, 8'h0F, 8'h2A, 8'hFE});
        pl_vec("pl_chip0", 1'b0, 8'h07, 8'h38, {8'hFE, 8'h07, 8'h38, 8'hF7, 8'hFE});

        // Simultaneous CPU write and player request after a fresh select of chip 0
        do_reset();
        cpu_vec(vecs[0], 100);
        cpu_wr    = 1'b1;
        cpu_a     = 1'b0;
        cpu_wdata = 8'h55;
        pl_chip   = 1'b1;
        pl_reg    = 8'h08;
        pl_data   = 8'h0F;
        cpu_req   = 1'b1;
        pl_req    = 1'b1;
        run(80);
        chk("sim_cpu_ack_cycle", cpu_ack_j, PH);
        chk("sim_cpu_bus", {22'd0, bdir_at[1], bc_at[1], di_at[1]}, {22'd0, 1'b1, 1'b0, 8'h55});
        chk("sim_gap_before_player", {30'd0, bdir_at[PH + 1], bdir_at[PH + 2]}, 32'b01);
        chk("sim_ack_counts", {cpu_ack_n[15:0], pl_ack_n[15:0]}, 32'h0001_0001);
        check_player("sim", PH + 2, {8'hFF, 8'h08, 8'h0F, 8'h00, 8'hFE}, 5'b11011);

        // Reset pulsed during player phase 2
        pl_chip = 1'b0;
        pl_reg  = 8'h10;
        pl_data = 8'h5A;
        pl_req  = 1'b1;
        repeat (2 * PH + 1) @(negedge CLK);
        chk("rst_phase2_bus", {22'd0, BDIR, BC, DI}, {22'd0, 1'b1, 1'b0, 8'h5A});
        #1;
        RESET_s = 1'b1;
        #1;
        chk("rst_bdir_drops", {30'd0, BDIR, busy}, 32'd0);
        chk("rst_shadows", {8'd0, dut.sel_sh, dut.adr_sh[0], dut.adr_sh[1]},
            {8'd0, 8'hFF, 8'h00, 8'h00});
        pl_req = 1'b0;
        @(negedge CLK);
        RESET_s = 1'b0;
        acks  = 0;
        highs = 0;
        for (int j = 0; j < 50; j++) begin
            @(negedge CLK);
            if (pl_ack || cpu_ack) acks++;
            if (BDIR || busy) highs++;
        end
        chk("rst_no_ack", acks, 0);
        chk("rst_stays_idle", highs, 0);
        chk("rst_di_cleared", DI, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
